// File: rtl/alu_wb_stage.sv
// ALU writeback stage: owns the architectural PSR and queues register-file writes.
// PSR updates 1 cycle after accept; 2-entry write queue, ready_o drops when it is full.
module alu_wb_stage #(
    parameter int DATA_WIDTH     = 8,
    parameter int ALUOP_WIDTH    = 4,
    parameter int APSR_WIDTH     = 4,
    parameter int PSR_WIDTH      = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [ALUOP_WIDTH-1:0]    operation_i,
    input  logic [DATA_WIDTH-1:0]     result_i,
    input  logic [APSR_WIDTH-1:0]     apsr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      wr_en_i,
    input  logic                      flags_en_i,
    input  logic                      psr_wr_i,
    input  logic [PSR_WIDTH-1:0]      psr_data_i,
    output logic [PSR_WIDTH-1:0]      psr_o,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_data_o,
    input  logic                      rf_ready_i,
    output logic [1:0]                pending_o
);

    localparam logic [ALUOP_WIDTH-1:0] ALU_NOP  = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = ALUOP_WIDTH'(2);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADDC = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUBC = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] ALU_NAND = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] ALU_NOR  = ALUOP_WIDTH'(6);
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = ALUOP_WIDTH'(7);
    localparam logic [ALUOP_WIDTH-1:0] ALU_XNOR = ALUOP_WIDTH'(8);

    localparam int APSR_ZERO = 1;
    localparam int APSR_NEG  = 2;
    localparam int ENTRY_W   = REG_ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0]        mem_q [2];
    logic [ENTRY_W-1:0]        mem_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic [PSR_WIDTH-1:0]      psr_q, psr_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      accept, push, pop;

    // ready depends only on registered count and rst, never on valid_i/rf_ready_i
    assign ready_o   = ~rst & ~count_q[1];
    assign rf_we_o   = (count_q != 2'd0);
    assign psr_o     = psr_q;
    assign rf_addr_o = addr_q;
    assign rf_data_o = data_q;
    assign pending_o = count_q;

    always_comb begin
        accept   = valid_i & ready_o;
        push     = accept & wr_en_i & (operation_i != ALU_NOP);
        pop      = rf_we_o & rf_ready_i;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        psr_d    = psr_q;
        addr_d   = addr_q;
        data_d   = data_q;

        if (push) begin
            mem_d[wr_ptr_q] = {rd_addr_i, result_i};
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Head is re-registered so the outputs hold their last value once drained
        if (count_d != 2'd0) begin
            {addr_d, data_d} = mem_d[rd_ptr_d];
        end

        if (accept && flags_en_i) begin
            case (operation_i)
                ALU_ADD, ALU_SUB, ALU_ADDC, ALU_SUBC: begin
                    psr_d[APSR_WIDTH-1:0] = apsr_i;
                end
                ALU_NAND, ALU_NOR, ALU_XOR, ALU_XNOR: begin
                    psr_d[APSR_ZERO] = apsr_i[APSR_ZERO];
                    psr_d[APSR_NEG]  = apsr_i[APSR_NEG];
                end
                default: psr_d = psr_q;
            endcase
        end
        if (psr_wr_i) begin
            psr_d = psr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            psr_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            psr_q    <= psr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the ALU.
- Captures `result` and `apsr` for each issued ALU operation and owns the architectural PSR. The registered PSR feeds back to the ALU `psr` input, so ADDC/SUBC see the carry one cycle later.
- Buffers destination-register writes in a 2-entry queue so register-file backpressure does not stall flag updates.

Parameters:
- DATA_WIDTH, 8, operand/result width (matches `DATA_WIDTH in defs.v)
- ALUOP_WIDTH, 4, ALU operation code width (`ALUOP_WIDTH)
- APSR_WIDTH, 4, arithmetic flag bits C/Z/N/V at `APSR_CARRY/`APSR_ZERO/`APSR_NEG/`APSR_OVF
- PSR_WIDTH, 8, full PSR width; bits [APSR_WIDTH-1:0] are the APSR
- REG_ADDR_WIDTH, 3, register-file address width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  ALU output valid this cycle
- ready_o  output  1  stage can accept (queue not full)
- operation_i  input  ALUOP_WIDTH  op that produced result_i
- result_i  input  DATA_WIDTH  ALU result
- apsr_i  input  APSR_WIDTH  ALU flags
- rd_addr_i  input  REG_ADDR_WIDTH  destination register
- wr_en_i  input  1  instruction writes rd
- flags_en_i  input  1  instruction updates flags
- psr_wr_i  input  1  control write of whole PSR (MSR-style)
- psr_data_i  input  PSR_WIDTH  value for psr_wr_i
- psr_o  output  PSR_WIDTH  architectural PSR, drives ALU psr
- rf_we_o  output  1  register-file write request
- rf_addr_o  output  REG_ADDR_WIDTH  write address
- rf_data_o  output  DATA_WIDTH  write data
- rf_ready_i  input  1  register file accepts write this cycle
- pending_o  output  2  queued writes (0..2), for hazard detection

Behaviour:
- Reset (rst=1 at a clock edge):
  - psr_o=0, rf_we_o=0, rf_addr_o=0, rf_data_o=0, pending_o=0.
  - ready_o=0 while rst is high; ready_o=1 on the first cycle after rst is released.
  - Reset mid-operation discards all queued writes and flags with no write-out.
- Accept: valid_i & ready_o at the rising edge. Inputs with valid_i=0 are ignored.
- Flag update on accept, visible on psr_o the next cycle (1-cycle latency), independent of rf_ready_i:
  - ALU_NOP: no flag change, no write, regardless of enables.
  - ALU_ADD/SUB/ADDC/SUBC with flags_en_i: psr_o[APSR_WIDTH-1:0] <= apsr_i.
  - ALU_NAND/NOR/XOR/XNOR with flags_en_i: only Z and N are updated; C and V are held.
  - psr_o[PSR_WIDTH-1:APSR_WIDTH] is never changed by ALU ops.
  - psr_wr_i=1: psr_o <= psr_data_i. It overrides any same-cycle flag update and does not depend on valid_i.
- Write queue: 2-entry FIFO of {addr,data}.
  - Push on accept when wr_en_i=1 and op≠NOP.
  - Head presented registered: rf_we_o=1 iff count>0, with rf_addr_o/rf_data_o from the head.
  - Pop when rf_we_o & rf_ready_i.
  - Empty-queue latency: accept at edge N → rf_we_o high after edge N; earliest pop at edge N+1.
  - When rf_we_o=0, rf_addr_o and rf_data_o hold their last values.
- Counter rules:
  - ready_o = (count<2) and not in reset.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - count=2 with no pop: ready_o=0 and upstream must hold.
  - Pointers wrap mod 2.
- pending_o = count, registered.
- No combinational path from valid_i to ready_o, or from rf_ready_i to ready_o.

Test Plan:
- Reset mid-queue: queue 2 writes, assert rst for 1 cycle → pending_o=0, rf_we_o=0, psr_o=0; ready_o=0 during rst and 1 the cycle after; no further writes emitted.
- ADD 0xFF+0x01: result_i=0x00, apsr_i C=1 Z=1, rd=3, wr/flags enabled, rf_ready_i=1 → psr_o C=1 Z=1 next cycle; rf_we_o=1 addr=3 data=0x00 for exactly one cycle.
- Carry preservation: psr C=1, then XOR 0xAA^0xAA with apsr_i=Z only → psr_o Z=1, N=0, C still 1.
- Backpressure: rf_ready_i=0, issue 3 ops back-to-back → third held (ready_o=0 after two accepts), pending_o=2, and flags from both accepted ops applied immediately. Release rf_ready_i → writes drain in order, ready_o reasserts.
- Priority and NOP: psr_wr_i=1 with psr_data_i=0x80 on the same cycle as an ADD setting C → psr_o=0x80. A NOP with wr/flags enabled → no write, psr_o unchanged.
- Simultaneous push/pop at count=1 → pending_o stays 1 and data order is correct.
